// File: rtl/stmt_lowerer_seq_accum.sv
`default_nettype none
// ============================================================================
// Module   : stmt_lowerer_seq_accum
// Purpose  : Registered command executor with an accumulator. It accepts
//            an opcode and data command over a valid/ready handshake and
//            runs LOAD, bit-serial SHL, saturating ADDS or CLR. The result
//            is held until downstream takes it.
// Revision : 1.0 - initial release
// ============================================================================
module stmt_lowerer_seq_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic             out_sat,
  output logic [CNT_W-1:0] op_count
);

  // Opcode encodings as seen on in_op / out_op
  localparam logic [1:0] c_op_load = 2'b00;
  localparam logic [1:0] c_op_shl  = 2'b01;
  localparam logic [1:0] c_op_adds = 2'b10;
  localparam logic [1:0] c_op_clr  = 2'b11;

  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero     = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_cnt;
  logic [1:0]       r_out_op;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_op_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum_sat;
  logic [WIDTH-1:0] w_acc_shl;
  logic             w_accept;
  logic             w_handoff;
  logic             w_last_shift;

  // The sum is one bit wider than the accumulator so that the top bit flags saturation
  assign w_sum        = {1'b0, r_acc} + {1'b0, in_data};
  assign w_carry      = w_sum[WIDTH];
  assign w_sum_sat    = w_carry ? c_all_ones : w_sum[WIDTH-1:0];
  // One step of the bit-serial shift: zero fill at the bottom, MSB dropped
  assign w_acc_shl    = {r_acc[WIDTH-2:0], 1'b0};
  assign w_accept     = in_valid & r_in_ready;
  assign w_handoff    = r_out_valid & out_ready;
  assign w_last_shift = (r_cnt == 3'd1);

  // Control FSM, accumulator datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= c_zero;
      r_cnt       <= 3'd0;
      r_out_data  <= c_zero;
      r_out_op    <= 2'b00;
      r_out_sat   <= 1'b0;
      r_op_count  <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_out_op   <= in_op;
            r_out_sat  <= 1'b0;
            r_in_ready <= 1'b0;
            case (in_op)
              c_op_load: begin
                r_acc       <= in_data;
                r_out_data  <= in_data;
                r_state     <= ST_HOLD;
                r_out_valid <= 1'b1;
              end
              c_op_clr: begin
                r_acc       <= c_zero;
                r_out_data  <= c_zero;
                r_state     <= ST_HOLD;
                r_out_valid <= 1'b1;
              end
              c_op_adds: begin
                r_acc       <= w_sum_sat;
                r_out_data  <= w_sum_sat;
                r_out_sat   <= w_carry;
                r_state     <= ST_HOLD;
                r_out_valid <= 1'b1;
              end
              c_op_shl: begin
                r_cnt <= in_data[2:0];
                if (in_data[2:0] == 3'd0) begin
                  // Zero shift: the accumulator is reported as it stands
                  r_out_data  <= r_acc;
                  r_state     <= ST_HOLD;
                  r_out_valid <= 1'b1;
                end else begin
                  r_state <= ST_EXEC;
                end
              end
              default: begin
                r_state <= ST_IDLE;
              end
            endcase
          end
        end

        ST_EXEC: begin
          // One shift per cycle; new commands wait until the result has been handed off
          r_acc <= w_acc_shl;
          r_cnt <= r_cnt - 3'd1;
          if (w_last_shift) begin
            r_out_data  <= w_acc_shl;
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (w_handoff) begin
            r_op_count  <= r_op_count + c_cnt_one;
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_op    = r_out_op;
  assign out_sat   = r_out_sat;
  assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_stmt_lowerer_seq_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_stmt_lowerer_seq_accum
// Purpose  : Self-checking bench for stmt_lowerer_seq_accum. A command-level
//            accumulator model sets the per-cycle expectations, and literal
//            values pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stmt_lowerer_seq_accum;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;
  logic             out_sat;
  logic [CNT_W-1:0] op_count;

  stmt_lowerer_seq_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_op   (out_op),
    .out_sat  (out_sat),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected DUT outputs for the current cycle
  logic             e_en = 1'b0;
  logic             e_in_ready;
  logic             e_out_valid;
  logic [WIDTH-1:0] e_data;
  logic [1:0]       e_op;
  logic             e_sat;
  logic [CNT_W-1:0] e_cnt;

  // Command-level model state
  logic [WIDTH-1:0] m_acc;
  int               m_count;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (e_en) begin
      chk("in_ready",  32'(in_ready),  32'(e_in_ready));
      chk("out_valid", 32'(out_valid), 32'(e_out_valid));
      chk("out_data",  32'(out_data),  32'(e_data));
      chk("out_op",    32'(out_op),    32'(e_op));
      chk("out_sat",   32'(out_sat),   32'(e_sat));
      chk("op_count",  32'(op_count),  32'(e_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-command effect on the accumulator, plus the extra EXEC cycles it costs
  task automatic model_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d,
                           output logic [WIDTH-1:0] res, output logic sat, output int lat);
    int s;
    sat = 1'b0;
    lat = 0;
    case (op)
      2'b00: m_acc = d;
      2'b01: begin
        lat   = int'(d[2:0]);
        m_acc = WIDTH'((int'(m_acc) * (1 << lat)) % (1 << WIDTH));
      end
      2'b10: begin
        s = int'(m_acc) + int'(d);
        if (s > (1 << WIDTH) - 1) begin
          m_acc = {WIDTH{1'b1}};
          sat   = 1'b1;
        end else begin
          m_acc = WIDTH'(s);
        end
      end
      default: m_acc = '0;
    endcase
    res = m_acc;
  endtask

  // Issue one command in an IDLE cycle, stall in HOLD for 'stall' cycles, then hand off
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d, input int stall);
    logic [WIDTH-1:0] res;
    logic             sat;
    int               lat;
    model_cmd(op, d, res, sat, lat);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    step();
    // Scramble the inputs so that any late sampling shows up
    in_valid   = 1'b0;
    in_op      = ~op;
    in_data    = ~d;
    e_in_ready = 1'b0;
    e_op       = op;
    e_sat      = sat;
    if (lat > 0) begin
      e_out_valid = 1'b0;
      repeat (lat) step();
    end
    e_out_valid = 1'b1;
    e_data      = res;
    out_ready   = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      in_op    = 2'($urandom);
      in_data  = WIDTH'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    m_count     = (m_count + 1) % (1 << CNT_W);
    e_cnt       = CNT_W'(m_count);
    e_out_valid = 1'b0;
    e_in_ready  = 1'b1;
    out_ready   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = '0; out_ready = 1'b0;
    m_acc = '0; m_count = 0;
    e_in_ready = 1'b1; e_out_valid = 1'b0; e_data = '0; e_op = 2'b00; e_sat = 1'b0; e_cnt = '0;

    // Reset held for two cycles
    step();
    e_en = 1'b1;
    step();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_op_count",  32'(op_count),  32'd0);
    rst = 1'b0;
    step();

    // LOAD followed by immediate handoff
    send(2'b00, 8'h5A, 0);
    chk("t1_data",  32'(out_data), 32'h5A);
    chk("t1_op",    32'(out_op),   32'h0);
    chk("t1_count", 32'(op_count), 32'd1);

    // Bit-serial shift by 3, then shift by 0
    send(2'b00, 8'h81, 0);
    send(2'b01, 8'h03, 0);
    chk("t2_shl3", 32'(out_data), 32'h08);
    send(2'b01, 8'h00, 0);
    chk("t2_shl0", 32'(out_data), 32'h08);

    // Saturating and non-saturating add
    send(2'b00, 8'hF0, 0);
    send(2'b10, 8'h20, 0);
    chk("t3_sat_data", 32'(out_data), 32'hFF);
    chk("t3_sat_flag", 32'(out_sat),  32'd1);
    send(2'b11, 8'hAA, 0);
    send(2'b10, 8'h7F, 0);
    chk("t3_add_data", 32'(out_data), 32'h7F);
    chk("t3_add_flag", 32'(out_sat),  32'd0);

    // Backpressure in HOLD with in_valid pulses
    send(2'b00, 8'h3C, 5);
    send(2'b01, 8'h02, 3);
    chk("t4_data", 32'(out_data), 32'hF0);

    // Reset during cycle 2 of a shift by 7
    send(2'b00, 8'h01, 0);
    in_valid = 1'b1; in_op = 2'b01; in_data = 8'h07;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    e_in_ready = 1'b0; e_op = 2'b01; e_sat = 1'b0; e_out_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_acc = '0; m_count = 0;
    e_in_ready = 1'b1; e_out_valid = 1'b0; e_data = '0; e_op = 2'b00; e_sat = 1'b0; e_cnt = '0;
    chk("t5_count", 32'(op_count), 32'd0);
    step();
    send(2'b10, 8'h01, 0);
    chk("t5_acc_zero", 32'(out_data), 32'h01);

    // Counter wrap
    for (int i = 0; i < 14; i++) send(2'b00, 8'(i), i % 3);
    chk("t6_count15", 32'(op_count), 32'd15);
    send(2'b11, 8'h00, 0);
    chk("t6_count0", 32'(op_count), 32'd0);

    step();
    e_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
